// File: rtl/nes_mem_arbiter.sv
// Arbitrates the NES CPU and PPU request streams onto one single-port memory:
// latches request pulses, sequences strobe/wait/capture and returns one-cycle acks.
module nes_mem_arbiter #(
    parameter int ADDR_W     = 22,
    parameter int READ_LAT   = 2,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic              ppu_busy,
    output logic              ppu_ack,
    output logic [7:0]        ppu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              overrun
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int ST_W  = $clog2(MAX_STREAK + 1);
    localparam logic [ST_W-1:0]  STREAK_MAX = ST_W'(MAX_STREAK);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(READ_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_cpu_busy;
    logic                r_cpu_we;
    logic [ADDR_W-1:0]   r_cpu_addr;
    logic [7:0]          r_cpu_wdata;
    logic                r_ppu_busy;
    logic [ADDR_W-1:0]   r_ppu_addr;
    logic                r_gnt_cpu;
    logic                r_gnt_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_wdata;
    logic [CNT_W-1:0]    r_cnt;
    logic [ST_W-1:0]     r_streak;
    logic [7:0]          r_cpu_rdata;
    logic [7:0]          r_ppu_rdata;
    logic                r_overrun;

    logic                w_grant;
    logic                w_pick_cpu;
    logic                w_cpu_ack;
    logic                w_ppu_ack;

    // PPU normally wins; the CPU only wins once the PPU has used its streak allowance.
    assign w_grant    = (r_state == S_IDLE) && (r_cpu_busy || r_ppu_busy);
    assign w_pick_cpu = r_cpu_busy && (!r_ppu_busy || (r_streak == STREAK_MAX));
    assign w_cpu_ack  = (r_state == S_DONE) &&  r_gnt_cpu;
    assign w_ppu_ack  = (r_state == S_DONE) && !r_gnt_cpu;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_ISSUE;
            S_ISSUE: w_next = r_gnt_we ? S_DONE : S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cpu_busy  <= 1'b0;
            r_cpu_we    <= 1'b0;
            r_cpu_addr  <= '0;
            r_cpu_wdata <= '0;
            r_ppu_busy  <= 1'b0;
            r_ppu_addr  <= '0;
            r_gnt_cpu   <= 1'b0;
            r_gnt_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cnt       <= '0;
            r_streak    <= '0;
            r_cpu_rdata <= '0;
            r_ppu_rdata <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state <= w_next;

            // A request landing on its own ack cycle refills the slot being freed.
            if (cpu_req) begin
                if (!r_cpu_busy || w_cpu_ack) begin
                    r_cpu_busy  <= 1'b1;
                    r_cpu_we    <= cpu_we;
                    r_cpu_addr  <= cpu_addr;
                    r_cpu_wdata <= cpu_wdata;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_cpu_ack) begin
                r_cpu_busy <= 1'b0;
            end

            if (ppu_req) begin
                if (!r_ppu_busy || w_ppu_ack) begin
                    r_ppu_busy <= 1'b1;
                    r_ppu_addr <= ppu_addr;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_ppu_ack) begin
                r_ppu_busy <= 1'b0;
            end

            if (w_grant) begin
                r_gnt_cpu  <= w_pick_cpu;
                r_gnt_we   <= w_pick_cpu && r_cpu_we;
                r_mem_addr <= w_pick_cpu ? r_cpu_addr : r_ppu_addr;
                if (w_pick_cpu) r_mem_wdata <= r_cpu_wdata;
                if (!w_pick_cpu && r_cpu_busy)
                    r_streak <= (r_streak == STREAK_MAX) ? r_streak : r_streak + 1'b1;
                else
                    r_streak <= '0;
            end

            if (r_state == S_ISSUE && !r_gnt_we) r_cnt <= CNT_LOAD;

            if (r_state == S_WAIT) begin
                if (r_cnt == '0) begin
                    if (r_gnt_cpu) r_cpu_rdata <= mem_rdata;
                    else           r_ppu_rdata <= mem_rdata;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign cpu_busy  = r_cpu_busy;
    assign cpu_ack   = w_cpu_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign ppu_busy  = r_ppu_busy;
    assign ppu_ack   = w_ppu_ack;
    assign ppu_rdata = r_ppu_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_rd    = (r_state == S_ISSUE) && !r_gnt_we;
    assign mem_wr    = (r_state == S_ISSUE) &&  r_gnt_we;
    assign mem_wdata = r_mem_wdata;
    assign overrun   = r_overrun;

endmodule
